// File: rtl/sha1_msg_padder.sv
// Byte-stream front end for the SHA1 core: packs message bytes into 512-bit
// blocks and appends 0x80, zero fill and the big-endian bit length.
module sha1_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last
);

    typedef enum logic [1:0] {FILL, EMIT, EXTRA} state_t;
    typedef logic [63:0][7:0] block_t;

    state_t           state;
    block_t           blk_q, blk_nxt;
    logic [5:0]       idx;
    logic [LEN_W-1:0] bitlen, bitlen_inc;
    logic             pend, pend_80;
    logic             accept, hs;

    assign accept     = in_valid & in_ready;
    assign hs         = blk_valid & blk_ready & (state == EMIT);
    assign bitlen_inc = bitlen + LEN_W'(8);
    assign blk_data   = blk_q;

    // Length field occupies bytes 56..63, most significant byte first.
    function automatic block_t put_len(input block_t b, input logic [LEN_W-1:0] len);
        block_t      r;
        logic [63:0] l64;
        r   = b;
        l64 = '0;
        l64[LEN_W-1:0] = len;
        for (int j = 0; j < 8; j++)
            r[56+j] = l64[63-8*j -: 8];
        return r;
    endfunction

    always_comb begin
        blk_nxt = blk_q;
        case (state)
            FILL: if (accept) begin
                blk_nxt[idx] = in_data;
                if (in_last) begin
                    if (idx != 6'd63)
                        blk_nxt[idx + 6'd1] = 8'h80;
                    if (idx <= 6'd54)
                        blk_nxt = put_len(blk_nxt, bitlen_inc);
                end
            end
            EMIT: if (hs) blk_nxt = '0;
            EXTRA: begin
                blk_nxt = put_len('0, bitlen);
                if (pend_80)
                    blk_nxt[0] = 8'h80;
            end
            default: blk_nxt = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= FILL;
            blk_q     <= '0;
            idx       <= '0;
            bitlen    <= '0;
            pend      <= 1'b0;
            pend_80   <= 1'b0;
            in_ready  <= 1'b0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
        end else begin
            blk_q <= blk_nxt;
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        idx    <= idx + 6'd1;
                        bitlen <= bitlen_inc;
                        if (in_last || idx == 6'd63) begin
                            state     <= EMIT;
                            in_ready  <= 1'b0;
                            blk_valid <= 1'b1;
                            // Last byte at 55 or later leaves no room for the length.
                            blk_last  <= in_last && (idx <= 6'd54);
                            pend      <= in_last && (idx >= 6'd55);
                            pend_80   <= in_last && (idx == 6'd63);
                        end
                    end
                end
                EMIT: if (hs) begin
                    blk_valid <= 1'b0;
                    blk_last  <= 1'b0;
                    idx       <= '0;
                    if (pend) begin
                        state <= EXTRA;
                    end else begin
                        state    <= FILL;
                        in_ready <= 1'b1;
                        if (blk_last)
                            bitlen <= '0;
                    end
                end
                EXTRA: begin
                    state     <= EMIT;
                    blk_valid <= 1'b1;
                    blk_last  <= 1'b1;
                    pend      <= 1'b0;
                    pend_80   <= 1'b0;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Directed bench for sha1_msg_padder: table of messages with hand-computed
// length fields, plus stall and mid-message reset sequences.
module tb_sha1_msg_padder;

    logic         CLK = 0;
    logic         nRST;
    logic         in_valid, in_ready, in_last;
    logic [7:0]   in_data;
    logic         blk_valid, blk_ready, blk_last;
    logic [511:0] blk_data;

    int total = 0;
    int bad   = 0;

    sha1_msg_padder #(.LEN_W(64)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last)
    );

    always #5 CLK = ~CLK;

    // pat: 0 = "abc..." (0x61+i), 1 = constant 0x41, 2 = ramp i
    typedef struct {
        int          len;
        int          pat;
        int          nblk;
        logic [15:0] lenfld;
        bit          rnd;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] msg_byte(input int pat, input int i);
        if (pat == 0) return 8'h61 + 8'(i);
        if (pat == 1) return 8'h41;
        return 8'(i);
    endfunction

    function automatic logic [511:0] exp_blk(input vec_t v, input int b);
        logic [511:0] r;
        logic [7:0]   x;
        int           p;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            p = b * 64 + j;
            x = (p < v.len) ? msg_byte(v.pat, p) : (p == v.len) ? 8'h80 : 8'h00;
            r[8*j +: 8] = x;
        end
        if (b == v.nblk - 1) begin
            r[8*62 +: 8] = v.lenfld[15:8];
            r[8*63 +: 8] = v.lenfld[7:0];
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the final accept.
    task automatic send_bytes(input int n, input int pat, input bit with_last);
        int cnt;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = msg_byte(pat, i);
            in_last  = with_last && (i == n - 1);
            cnt = 0;
            while (!in_ready && cnt < 500) begin
                @(negedge CLK);
                cnt++;
            end
            if (cnt >= 500) begin
                total++; bad++;
                $display("FAIL send_timeout got=byte%0d want=accepted", i);
                break;
            end
            @(negedge CLK);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic collect(input vec_t v, input int id);
        int b   = 0;
        int cyc = 0;
        while (b < v.nblk && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
            blk_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (blk_valid && blk_ready) begin
                chk($sformatf("v%0d_blk%0d_data", id, b), blk_data, exp_blk(v, b));
                chk($sformatf("v%0d_blk%0d_last", id, b), 512'(blk_last), 512'(b == v.nblk - 1));
                b++;
            end
        end
        if (b < v.nblk) begin
            total++; bad++;
            $display("FAIL v%0d_timeout got=%0d want=%0d blocks", id, b, v.nblk);
        end
        blk_ready = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        fork
            send_bytes(v.len, v.pat, 1'b1);
            collect(v, id);
        join
        @(negedge CLK);
    endtask

    initial begin
        logic [511:0] snap;
        vecs[0] = '{len:3,   pat:0, nblk:1, lenfld:16'h0018, rnd:0};
        vecs[1] = '{len:54,  pat:2, nblk:1, lenfld:16'h01B0, rnd:0};
        vecs[2] = '{len:55,  pat:2, nblk:1, lenfld:16'h01B8, rnd:0};
        vecs[3] = '{len:56,  pat:1, nblk:2, lenfld:16'h01C0, rnd:0};
        vecs[4] = '{len:63,  pat:2, nblk:2, lenfld:16'h01F8, rnd:0};
        vecs[5] = '{len:64,  pat:2, nblk:2, lenfld:16'h0200, rnd:0};
        vecs[6] = '{len:1,   pat:2, nblk:1, lenfld:16'h0008, rnd:0};
        vecs[7] = '{len:65,  pat:2, nblk:2, lenfld:16'h0208, rnd:1};
        vecs[8] = '{len:120, pat:2, nblk:3, lenfld:16'h03C0, rnd:1};

        nRST = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; blk_ready = 1'b1;
        #1;
        chk("rst_valid", 512'(blk_valid), 512'(0));
        chk("rst_last",  512'(blk_last),  512'(0));
        chk("rst_data",  blk_data,        '0);
        repeat (2) @(negedge CLK);
        chk("rst_ready", 512'(in_ready), 512'(0));
        nRST = 1'b1;
        @(negedge CLK);
        chk("post_rst_ready", 512'(in_ready), 512'(1));

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i], i);

        // Backpressure: block must hold while the consumer stalls.
        blk_ready = 1'b0;
        send_bytes(3, 0, 1'b1);
        snap = blk_data;
        chk("stall_lo",  512'(blk_data[31:0]),    512'(32'h80636261));
        chk("stall_len", 512'(blk_data[511:504]), 512'(8'h18));
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("stall%0d_valid", c), 512'(blk_valid), 512'(1));
            chk($sformatf("stall%0d_data", c),  blk_data, snap);
            chk($sformatf("stall%0d_ready", c), 512'(in_ready), 512'(0));
            @(negedge CLK);
        end
        chk("stall_last", 512'(blk_last), 512'(1));
        blk_ready = 1'b1;
        @(negedge CLK);
        chk("after_hs_ready", 512'(in_ready),  512'(1));
        chk("after_hs_valid", 512'(blk_valid), 512'(0));

        // Reset in the middle of a message discards it.
        send_bytes(20, 2, 1'b0);
        nRST = 1'b0;
        #1;
        chk("midrst_valid", 512'(blk_valid), 512'(0));
        chk("midrst_data",  blk_data,        '0);
        chk("midrst_ready", 512'(in_ready),  512'(0));
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        run_vec(vecs[0], 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
